cg_mem_beh: RTL and testbench



---
 rtl/cg_memory_pkg.sv | 13 +
 rtl/cg_mem_rd_buf.sv | 51 +++++
 rtl/cg_mem_beh.sv | 76 +++++++
 tb/tb_cg_mem_beh.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cg_memory_pkg.sv
// Shared constants and helpers for the behavioural word memory (cg_mem_beh).
package cg_memory_pkg;

    localparam int CG_MEM_DATA_WIDTH = 32;
    localparam int CG_MEM_ADDR_WIDTH = 32;
    localparam int CG_MEM_WORD_NUM   = 1024;

    // Number of low address bits used to index an array of word_num words.
    function automatic int cg_mem_idx_width(input int word_num);
        return $clog2(word_num);
    endfunction

endpackage

// File: rtl/cg_mem_rd_buf.sv
// One-entry read output register with valid/ready handshaking.
// Handshake: a request is taken on an edge where req_valid && req_ready; the
// word captured then is presented on rdata with rdata_valid set on the next
// cycle, and held until rdata_valid && rdata_ready. A new request may be taken
// in the same cycle the held word is consumed, giving one read per cycle.
module cg_mem_rd_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready
);

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  accept;

    // Accept when the register is empty or being drained; otherwise hold.
    always_comb begin
        req_ready     = !i_rst && (!rdata_valid_q || rdata_ready);
        accept        = req_valid && req_ready;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        if (accept) begin
            rdata_d       = rd_word;
            rdata_valid_d = 1'b1;
        end else if (rdata_valid_q && rdata_ready) begin
            rdata_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any in-flight word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: rtl/cg_mem_beh.sv
// Behavioural word memory: a write channel plus a valid/ready read channel.
// Addresses are word addresses folded onto the low index bits of the array.
// Build option: define CG_MEM_BEH_BYPASS_EN for write-first forwarding on a
// same-edge read/write of one index; left undefined the read is read-first.
module cg_mem_beh
    import cg_memory_pkg::*;
#(
    parameter int DATA_WIDTH = CG_MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = CG_MEM_ADDR_WIDTH,
    parameter int WORD_NUM   = CG_MEM_WORD_NUM
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  wen,
    input  logic                  wdata_valid,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    input  logic                  raddr_valid,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  raddr_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready
);

    localparam int IDX_W = cg_mem_idx_width(WORD_NUM);

    // Contents start at zero and survive reset.
    logic [DATA_WIDTH-1:0] mem_q [WORD_NUM] = '{default: '0};

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Address bits above the index are aliased away on purpose.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{waddr[ADDR_WIDTH-1:IDX_W], raddr[ADDR_WIDTH-1:IDX_W]};

    // Index folding, write qualification and the word offered to the read buffer.
    always_comb begin
        wr_en   = !i_rst && wen && wdata_valid;
        wr_idx  = waddr[IDX_W-1:0];
        rd_idx  = raddr[IDX_W-1:0];
        rd_word = mem_q[rd_idx];
`ifdef CG_MEM_BEH_BYPASS_EN
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_word = wdata;
        end
`endif
    end

    // Write port: never stalls, one word per cycle.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wdata;
        end
    end

    assign wdata_ready = !i_rst;

    cg_mem_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .req_valid   (raddr_valid),
        .req_ready   (raddr_ready),
        .rd_word     (rd_word),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready)
    );

endmodule

// File: tb/tb_cg_mem_beh.sv
// Bench for cg_mem_beh: directed scenarios plus random traffic against a
// reference memory array and a queue of read words awaiting delivery.
// Honours CG_MEM_BEH_BYPASS_EN for the same-edge read/write expectation.
module tb_cg_mem_beh;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        wen, wdata_valid, raddr_valid, rdata_ready;
    logic [31:0] waddr, wdata, raddr;
    logic        wdata_ready, raddr_ready, rdata_valid;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [1024];
    logic [31:0] exp_q [$];
    logic [31:0] model_rdata = '0;

    cg_mem_beh dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .wen         (wen),
        .wdata_valid (wdata_valid),
        .waddr       (waddr),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .raddr_valid (raddr_valid),
        .raddr       (raddr),
        .raddr_ready (raddr_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // Drive one cycle of inputs, advance one edge, update the reference.
    task automatic drive_cycle(input logic rst, input logic we, input logic wv,
                               input logic [31:0] wa, input logic [31:0] wd,
                               input logic rv, input logic [31:0] ra, input logic rr);
        logic        do_w, con, acc;
        logic [31:0] rd_val;
        i_rst = rst; wen = we; wdata_valid = wv; waddr = wa; wdata = wd;
        raddr_valid = rv; raddr = ra; rdata_ready = rr;
        do_w   = !rst && we && wv;
        con    = !rst && (exp_q.size() != 0) && rr;
        acc    = !rst && rv && ((exp_q.size() == 0) || rr);
        rd_val = model_mem[ra % 1024];
`ifdef CG_MEM_BEH_BYPASS_EN
        if (do_w && ((wa % 1024) == (ra % 1024))) rd_val = wd;
`endif
        @(posedge i_clk);
        if (rst) begin
            exp_q.delete();
            model_rdata = '0;
        end else begin
            if (con) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(rd_val);
                model_rdata = rd_val;
            end
        end
        if (do_w) model_mem[wa % 1024] = wd;
        #1;
    endtask

    task automatic idle(input logic rr);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rr);
    endtask

    task automatic test_reset;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rdata_valid); end
        checks++; if (raddr_ready !== 1'b0) begin errors++; $display("FAIL reset_raddr_ready got %b want 0", raddr_ready); end
        checks++; if (wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready got %b want 0", wdata_ready); end
        idle(1'b1);
        checks++; if (wdata_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wdata_ready got %b want 1", wdata_ready); end
        checks++; if (raddr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_raddr_ready got %b want 1", raddr_ready); end
    endtask

    task automatic test_write_read;
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h514, 32'h0000_0114, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h515, 32'h0000_0214, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h516, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h514, 1'b1);
        checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid got %b want 1", rdata_valid); end
        checks++; if (rdata !== 32'h0000_0114) begin errors++; $display("FAIL wr_rd_data got %h want 00000114", rdata); end
        idle(1'b1);
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", rdata_valid); end
        checks++; if (rdata !== 32'h0000_0114) begin errors++; $display("FAIL drain_hold_data got %h want 00000114", rdata); end
    endtask

    task automatic test_same_edge;
        logic [31:0] want;
`ifdef CG_MEM_BEH_BYPASS_EN
        want = 32'h0000_0314;
`else
        want = 32'hAAAA_AAAA;
`endif
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h516, 32'h0000_0314, 1'b1, 32'h516, 1'b1);
        checks++; if (rdata !== want) begin errors++; $display("FAIL same_edge_data got %h want %h", rdata, want); end
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h516, 1'b1);
        checks++; if (rdata !== 32'h0000_0314) begin errors++; $display("FAIL after_same_edge got %h want 00000314", rdata); end
        idle(1'b1);
    endtask

    task automatic test_alias;
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h514, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h114, 1'b1);
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL alias_data got %h want 12345678", rdata); end
        idle(1'b1);
    endtask

    task automatic test_backpressure;
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h515, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h514, 1'b0);
            checks++; if (rdata !== 32'h0000_0214 || rdata_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got %h/%b want 00000214/1", i, rdata, rdata_valid);
            end
            checks++; if (raddr_ready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d] got %b want 0", i, raddr_ready); end
        end
        rdata_ready = 1'b1;
        #1;
        checks++; if (raddr_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", raddr_ready); end
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h514, 1'b1);
        checks++; if (rdata !== 32'h1234_5678 || rdata_valid !== 1'b1) begin
            errors++; $display("FAIL bp_next_read got %h/%b want 12345678/1", rdata, rdata_valid);
        end
        idle(1'b1);
    endtask

    task automatic test_partial_write;
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h516, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h516, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h516, 1'b1);
        checks++; if (rdata !== 32'h0000_0314) begin errors++; $display("FAIL partial_write got %h want 00000314", rdata); end
        idle(1'b1);
    endtask

    task automatic test_reset_mid;
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h514, 1'b0);
        checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", rdata_valid); end
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h515, 32'hFFFF_0000, 1'b1, 32'h515, 1'b0);
        checks++; if (rdata !== 32'h0 || rdata_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out got %h/%b want 0/0", rdata, rdata_valid);
        end
        checks++; if (raddr_ready !== 1'b0 || wdata_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ready got %b/%b want 0/0", raddr_ready, wdata_ready);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h515, 1'b1);
        checks++; if (rdata !== 32'h0000_0214) begin errors++; $display("FAIL mid_preserved got %h want 00000214", rdata); end
        idle(1'b1);
    endtask

    task automatic test_random;
        logic [31:0] wa, ra;
        logic        rr;
        for (int i = 0; i < 300; i++) begin
            wa = ($urandom_range(0, 7) << 10) | 32'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) << 10) | 32'($urandom_range(0, 15));
            rr = ($urandom_range(0, 3) != 0);
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa, $urandom,
                        1'($urandom_range(0, 1)), ra, rr);
            checks++; if (rdata_valid !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid[%0d] got %b want %b", i, rdata_valid, exp_q.size() != 0);
            end
            checks++; if (rdata !== model_rdata) begin
                errors++; $display("FAIL rand_data[%0d] got %h want %h", i, rdata, model_rdata);
            end
            checks++; if (raddr_ready !== ((exp_q.size() == 0) || rr)) begin
                errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, raddr_ready, (exp_q.size() == 0) || rr);
            end
        end
        idle(1'b1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        i_rst = 1'b1; wen = 1'b0; wdata_valid = 1'b0; waddr = '0; wdata = '0;
        raddr_valid = 1'b0; raddr = '0; rdata_ready = 1'b1;
        test_reset;
        test_write_read;
        test_same_edge;
        test_alias;
        test_backpressure;
        test_partial_write;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
